// File: rtl/ringed_squid_pkg.sv
// Shared constants, opcode encodings and FSM state type for the ringed_squid 4-bit accumulator core.
package ringed_squid_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 4;

  localparam logic [ADDR_W-1:0] HALT_ADDR = 11'h7FF;
  localparam logic [ADDR_W-1:0] RESET_PC  = 11'h000;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_NOT = 4'hC;
  localparam logic [3:0] OP_SHL = 4'hD;
  localparam logic [3:0] OP_SHR = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_OP_HI,
    ST_OP_MID,
    ST_OP_LO,
    ST_EXEC,
    ST_IMM,
    ST_HALT
  } state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= OP_LDA) && (op <= OP_XOR);
  endfunction

  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
  endfunction

endpackage

// File: rtl/ringed_squid_alu.sv
// Combinational ALU: result, carry and zero plus write enables telling the core which state to update.
// SHL/SHR exist only when RINGED_SQUID_SHIFT_EN is defined.
module ringed_squid_alu
  import ringed_squid_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] m,
  output logic [DATA_W-1:0] res,
  output logic              c_out,
  output logic              z_out,
  output logic              acc_we,
  output logic              c_we
);

  logic [DATA_W:0] sum;

  always_comb begin
    res    = '0;
    c_out  = 1'b0;
    acc_we = 1'b0;
    c_we   = 1'b0;
    sum    = '0;
    case (op)
      OP_LDA, OP_LDI: begin
        res    = m;
        acc_we = 1'b1;
      end
      OP_ADD: begin
        sum    = {1'b0, acc} + {1'b0, m};
        res    = sum[DATA_W-1:0];
        c_out  = sum[DATA_W];
        acc_we = 1'b1;
        c_we   = 1'b1;
      end
      OP_SUB: begin
        // carry out of ACC + ~M + 1 is the inverted borrow
        sum    = {1'b0, acc} + {1'b0, ~m} + {{DATA_W{1'b0}}, 1'b1};
        res    = sum[DATA_W-1:0];
        c_out  = sum[DATA_W];
        acc_we = 1'b1;
        c_we   = 1'b1;
      end
      OP_AND: begin res = acc & m; acc_we = 1'b1; end
      OP_OR:  begin res = acc | m; acc_we = 1'b1; end
      OP_XOR: begin res = acc ^ m; acc_we = 1'b1; end
      OP_NOT: begin res = ~acc;    acc_we = 1'b1; end
`ifdef RINGED_SQUID_SHIFT_EN
      OP_SHL: begin
        res    = {acc[DATA_W-2:0], 1'b0};
        c_out  = acc[DATA_W-1];
        acc_we = 1'b1;
        c_we   = 1'b1;
      end
      OP_SHR: begin
        res    = {1'b0, acc[DATA_W-1:1]};
        c_out  = acc[0];
        acc_we = 1'b1;
        c_we   = 1'b1;
      end
`else
      OP_SHL, OP_SHR: ;
`endif
      default: ;
    endcase
    z_out = (res == '0);
  end

endmodule

// File: rtl/ringed_squid_cpu.sv
// 4-bit accumulator CPU core driving an external combinational 2048x4 RAM over the TinyTapeout pins.
// Define RINGED_SQUID_SHIFT_EN to enable the SHL/SHR opcodes (otherwise they behave as NOP).
module ringed_squid_cpu
  import ringed_squid_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   opnd;
  logic [3:0]          ir;
  logic [DATA_W-1:0]   acc;
  logic                z;
  logic                c;

  logic [DATA_W-1:0]   d;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   pc_inc;
  logic                rw;
  logic [3:0]          alu_op;
  logic                exec_now;
  logic                jump_taken;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_z;
  logic                alu_acc_we;
  logic                alu_c_we;
  logic                unused_pins;

  assign d           = uio_in[3:0];
  assign unused_pins = ^{ena, ui_in, uio_in[7:4]};
  assign pc_inc      = pc + 1'b1;

  // single-nibble ops execute on the fetch edge, so the ALU sees the opcode straight off the bus
  assign alu_op   = (state == ST_FETCH) ? d : ir;
  assign exec_now = (state == ST_EXEC) || (state == ST_IMM) ||
                    ((state == ST_FETCH) && ((d == OP_NOT) || (d == OP_SHL) || (d == OP_SHR)));
  assign jump_taken = (ir == OP_JMP) || ((ir == OP_JZ) && z) || ((ir == OP_JC) && c);

  ringed_squid_alu u_alu (
    .op     (alu_op),
    .acc    (acc),
    .m      (d),
    .res    (alu_res),
    .c_out  (alu_c),
    .z_out  (alu_z),
    .acc_we (alu_acc_we),
    .c_we   (alu_c_we)
  );

  always_comb begin
    case (state)
      ST_EXEC: addr = opnd;
      ST_HALT: addr = HALT_ADDR;
      default: addr = pc;
    endcase
  end

  assign rw      = (state == ST_EXEC) && (ir == OP_STA);
  assign uo_out  = {rw, addr[ADDR_W-1:4]};
  assign uio_out = {addr[3:0], rw ? acc : '0};
  assign uio_oe  = {4'hF, {4{rw}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      opnd  <= '0;
      ir    <= OP_NOP;
      acc   <= '0;
      z     <= 1'b0;
      c     <= 1'b0;
    end else begin
      if (exec_now) begin
        if (alu_acc_we) begin
          acc <= alu_res;
          z   <= alu_z;
        end
        if (alu_c_we) c <= alu_c;
      end
      case (state)
        ST_FETCH: begin
          ir <= d;
          pc <= pc_inc;
          if (d == OP_HLT)                     state <= ST_HALT;
          else if (d == OP_LDI)                state <= ST_IMM;
          else if (is_mem_op(d) || is_jump(d)) state <= ST_OP_HI;
          else                                 state <= ST_FETCH;
        end
        ST_OP_HI: begin
          opnd[ADDR_W-1:8] <= d[2:0];
          pc               <= pc_inc;
          state            <= ST_OP_MID;
        end
        ST_OP_MID: begin
          opnd[7:4] <= d;
          pc        <= pc_inc;
          state     <= ST_OP_LO;
        end
        ST_OP_LO: begin
          opnd[3:0] <= d;
          if (is_jump(ir)) begin
            pc    <= jump_taken ? {opnd[ADDR_W-1:4], d} : pc_inc;
            state <= ST_FETCH;
          end else begin
            pc    <= pc_inc;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: state <= ST_FETCH;
        ST_IMM: begin
          pc    <= pc_inc;
          state <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ringed_squid_cpu.sv
// Self-checking bench: directed programs plus random programs compared against an instruction-level model.
module tb_ringed_squid_cpu;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic [3:0]  ram  [2048];
  logic [3:0]  mram [2048];
  logic [3:0]  junk;
  logic [10:0] bus_addr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ringed_squid_cpu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_addr = {uo_out[6:0], uio_out[7:4]};
  assign uio_in   = {junk, ram[bus_addr]};

  always @(posedge clk) begin
    if (uo_out[7]) ram[bus_addr] = uio_out[3:0];
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction-level reference: returns total cycles up to and including HLT, 0 if it never halts.
  function automatic int unsigned model_run();
    int unsigned pc = 0, cyc = 0, a = 0, acc = 0;
    bit z = 0, c = 0;
    int unsigned op;
    for (int unsigned k = 0; k < 4000; k++) begin
      op = mram[pc];
      pc = (pc + 1) % 2048;
      if ((op >= 1 && op <= 7) || (op >= 9 && op <= 11)) begin
        a  = (mram[pc] % 8) * 256 + mram[(pc + 1) % 2048] * 16 + mram[(pc + 2) % 2048];
        pc = (pc + 3) % 2048;
      end
      case (op)
        1: begin acc = mram[a]; z = (acc == 0); cyc += 5; end
        2: begin mram[a] = 4'(acc); cyc += 5; end
        3: begin acc = acc + mram[a]; c = (acc > 15); acc = acc % 16; z = (acc == 0); cyc += 5; end
        4: begin acc = acc + (15 - mram[a]) + 1; c = (acc > 15); acc = acc % 16; z = (acc == 0); cyc += 5; end
        5: begin acc = acc & mram[a]; z = (acc == 0); cyc += 5; end
        6: begin acc = acc | mram[a]; z = (acc == 0); cyc += 5; end
        7: begin acc = acc ^ mram[a]; z = (acc == 0); cyc += 5; end
        8: begin acc = mram[pc]; pc = (pc + 1) % 2048; z = (acc == 0); cyc += 2; end
        9, 10, 11: begin
          cyc += 4;
          if (op == 9 || (op == 10 && z) || (op == 11 && c)) pc = a;
        end
        12: begin acc = 15 - acc; z = (acc == 0); cyc += 1; end
`ifdef RINGED_SQUID_SHIFT_EN
        13: begin c = (acc >= 8); acc = (acc * 2) % 16; z = (acc == 0); cyc += 1; end
        14: begin c = (acc % 2) == 1; acc = acc / 2; z = (acc == 0); cyc += 1; end
`endif
        15: return cyc + 1;
        default: cyc += 1;
      endcase
    end
    return 0;
  endfunction

  task automatic clear_ram();
    for (int unsigned i = 0; i < 2048; i++) ram[i] = 4'($urandom);
  endtask

  task automatic load(input int unsigned base, input int unsigned n, input logic [63:0] v);
    for (int unsigned i = 0; i < n; i++) ram[(base + i) % 2048] = v[4*(n-1-i) +: 4];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_prog(input string name, input int unsigned probe_cyc, input logic [10:0] probe_addr);
    int unsigned exp_cyc, n, mism;
    for (int unsigned i = 0; i < 2048; i++) mram[i] = ram[i];
    exp_cyc = model_run();
    junk = 4'($urandom);
    do_reset();
    n = 0;
    while (bus_addr != 11'h7FF && n < exp_cyc + 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == probe_cyc) check({name, "_probe"}, 32'(bus_addr), 32'(probe_addr));
    end
    check({name, "_cycles"}, n, exp_cyc);
    mism = 0;
    for (int unsigned i = 0; i < 2048; i++) if (ram[i] !== mram[i]) mism++;
    check({name, "_ram_mismatches"}, mism, 0);
    repeat (3) @(negedge clk);
    check({name, "_park"}, {8'h00, uo_out, uio_out, uio_oe}, 32'h007FF0F0);
  endtask

  task automatic gen_random();
    int unsigned pos, k;
    logic [3:0]  op;
    logic [10:0] a;
    clear_ram();
    pos = 0;
    while (pos < 'h60) begin
      op = 4'($urandom_range(0, 14));
      if (op >= 1 && op <= 7) begin
        a = 11'('h100 + $urandom_range(0, 15));
        ram[pos] = op; ram[pos+1] = {1'($urandom), a[10:8]};
        ram[pos+2] = a[7:4]; ram[pos+3] = a[3:0];
        pos += 4;
      end else if (op == 8) begin
        ram[pos] = op;
        pos += 2;
      end else if (op >= 9 && op <= 11) begin
        k = $urandom_range(0, 3);
        a = 11'(pos + 4 + k);
        ram[pos] = op; ram[pos+1] = {1'($urandom), a[10:8]};
        ram[pos+2] = a[7:4]; ram[pos+3] = a[3:0];
        for (int unsigned j = 0; j < k; j++) begin
          op = 4'($urandom_range(0, 3));
          ram[pos+4+j] = (op == 0) ? 4'h0 : 4'(op + 11);
        end
        pos += 4 + k;
      end else begin
        ram[pos] = op;
        pos += 1;
      end
    end
    ram[pos] = 4'hF;
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    ui_in = 8'h00;
    junk  = 4'h0;
    clear_ram();
    @(negedge clk);
    check("reset_pins", {8'h00, uo_out, uio_out, uio_oe}, 32'h000000F0);
    rst_n = 1'b1;
    check("first_read_addr", {21'h0, uo_out[7], bus_addr}, 32'h0);

    clear_ram();
    load(0, 7, 64'h852040F);
    run_prog("lda_sta_hlt", 0, 11'h0);
    check("sta_result", 32'(ram['h040]), 32'h5);

    clear_ram();
    load(0, 15, 64'h8930412042B020F);
    ram['h020] = 4'hF;
    ram['h041] = 4'h8;
    run_prog("add_carry", 16, 11'h020);
    check("add_result", 32'(ram['h042]), 32'h1);

    clear_ram();
    load(0, 14, 64'h8340412044A020);
    load('h00E, 7, 64'h812045F);
    load('h020, 7, 64'h8A2045F);
    ram['h041] = 4'h3;
    run_prog("sub_jz_taken", 16, 11'h020);
    check("sub_zero", {28'h0, ram['h044]}, 32'h0);
    check("jz_taken_path", {28'h0, ram['h045]}, 32'hA);

    clear_ram();
    load(0, 14, 64'h8240412044A020);
    load('h00E, 7, 64'h812045F);
    load('h020, 7, 64'h8A2045F);
    ram['h041] = 4'h3;
    run_prog("sub_jz_fall", 16, 11'h00E);
    check("sub_borrow", {28'h0, ram['h044]}, 32'hF);
    check("jz_fall_path", {28'h0, ram['h045]}, 32'h1);

    clear_ram();
    load(0, 12, 64'h89D2050B020F);
    load('h020, 7, 64'h872051F);
    ram['h051] = 4'h0;
`ifdef RINGED_SQUID_SHIFT_EN
    run_prog("shift", 12, 11'h020);
    check("shl_result", {28'h0, ram['h050]}, 32'h2);
    check("shl_carry_path", {28'h0, ram['h051]}, 32'h7);
`else
    run_prog("shift", 12, 11'h00B);
    check("shl_nop_result", {28'h0, ram['h050]}, 32'h9);
    check("shl_nop_carry_path", {28'h0, ram['h051]}, 32'h0);
`endif

    clear_ram();
    load(0, 7, 64'h872060F);
    ram['h060] = 4'h3;
    do_reset();
    for (int unsigned i = 0; i < 20 && !uo_out[7]; i++) @(negedge clk);
    check("sta_exec_rw", {31'h0, uo_out[7]}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midsta_reset_pins", {8'h00, uo_out, uio_out, uio_oe}, 32'h000000F0);
    repeat (2) @(negedge clk);
    check("midsta_no_write", {28'h0, ram['h060]}, 32'h3);
    rst_n = 1'b1;
    check("midsta_restart_addr", {21'h0, uo_out[7], bus_addr}, 32'h0);
    run_prog("midsta_rerun", 0, 11'h0);
    check("midsta_final", {28'h0, ram['h060]}, 32'h7);

    for (int unsigned t = 0; t < 25; t++) begin
      gen_random();
      run_prog($sformatf("rand%0d", t), 0, 11'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
